// File: rtl/vga_bounce_box.sv
// ---------------------------------------------------------------------------
// vga_bounce_box
// Pixel-generation stage placed directly after the vga timing core. Draws a
// solid square on a flat background. The square moves STEP pixels per axis
// once per frame, bounces off the screen edges, and steps its colour
// (RED -> GREEN -> BLUE -> RED) on every frame in which a bounce occurs.
//
// Ports:
//   board_clock   pixel clock shared with the vga timing core
//   reset         asynchronous, active-high
//   hsync_in      raw hsync from the timing core (active low)
//   vsync_in      raw vsync from the timing core (active low)
//   active_in     high while x_val/y_val are inside the visible area
//   x_val, y_val  current pixel column / row
//   pause         high freezes box position and colour
//   hsync, vsync  syncs delayed by 2 clocks to line up with RGB
//   red, green, blue  registered 8-bit colour channels
//
// Every output lags its inputs by exactly 2 clocks. Stage 1 registers the
// raw inputs; stage 2 registers the RGB result and the stage-1 syncs.
// ---------------------------------------------------------------------------
module vga_bounce_box #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter int          INIT_X   = 100,
    parameter int          INIT_Y   = 60,
    parameter logic [7:0]  BG_LEVEL = 8'h10
) (
    input  logic       board_clock,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic [9:0] x_val,
    input  logic [9:0] y_val,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    // Box arithmetic runs at 11 bits so that box_x + BOX_SIZE never wraps.
    localparam logic [10:0] X_MAX_C  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX_C  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_C   = 11'(STEP);
    localparam logic [10:0] BOX_C    = 11'(BOX_SIZE);
    localparam logic [10:0] INIT_X_C = 11'(INIT_X);
    localparam logic [10:0] INIT_Y_C = 11'(INIT_Y);

    typedef enum logic [1:0] {
        COL_RED   = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2
    } colour_t;

    logic [9:0]  s1_x_r;
    logic [9:0]  s1_y_r;
    logic        s1_active_r;
    logic        s1_hs_r;
    logic        s1_vs_r;
    logic        vs_q_r;

    logic [10:0] box_x_r;
    logic [10:0] box_y_r;
    logic        dir_x_r;     // 1 = moving right (+)
    logic        dir_y_r;     // 1 = moving down (+)
    colour_t     colour_r;

    logic        update_s;
    logic [10:0] box_x_next_s;
    logic [10:0] box_y_next_s;
    logic        dir_x_next_s;
    logic        dir_y_next_s;
    logic        bounce_x_s;
    logic        bounce_y_s;
    colour_t     colour_next_s;
    logic [23:0] box_rgb_s;
    logic [23:0] rgb_next_s;
    logic        in_box_s;
    logic [10:0] x_ext_s;
    logic [10:0] y_ext_s;

    // One update per frame, on the falling edge of vsync_in; pause suppresses
    // the update but the edge is still consumed because vs_q_r always tracks.
    assign update_s = vs_q_r & ~vsync_in & ~pause;

    // Stage 1 input register and vsync edge sampler.
    always_ff @(posedge board_clock or posedge reset) begin
        if (reset) begin
            s1_x_r      <= 10'd0;
            s1_y_r      <= 10'd0;
            s1_active_r <= 1'b0;
            s1_hs_r     <= 1'b1;
            s1_vs_r     <= 1'b1;
            vs_q_r      <= 1'b1;
        end else begin
            s1_x_r      <= x_val;
            s1_y_r      <= y_val;
            s1_active_r <= active_in;
            s1_hs_r     <= hsync_in;
            s1_vs_r     <= vsync_in;
            vs_q_r      <= vsync_in;
        end
    end

    // Next box position and direction, with wall clamping on bounce.
    always_comb begin
        box_x_next_s = box_x_r;
        box_y_next_s = box_y_r;
        dir_x_next_s = dir_x_r;
        dir_y_next_s = dir_y_r;
        bounce_x_s   = 1'b0;
        bounce_y_s   = 1'b0;
        if (update_s) begin
            if (dir_x_r) begin
                if (box_x_r + STEP_C >= X_MAX_C) begin
                    box_x_next_s = X_MAX_C;
                    dir_x_next_s = 1'b0;
                    bounce_x_s   = 1'b1;
                end else begin
                    box_x_next_s = box_x_r + STEP_C;
                end
            end else begin
                if (box_x_r <= STEP_C) begin
                    box_x_next_s = 11'd0;
                    dir_x_next_s = 1'b1;
                    bounce_x_s   = 1'b1;
                end else begin
                    box_x_next_s = box_x_r - STEP_C;
                end
            end
            if (dir_y_r) begin
                if (box_y_r + STEP_C >= Y_MAX_C) begin
                    box_y_next_s = Y_MAX_C;
                    dir_y_next_s = 1'b0;
                    bounce_y_s   = 1'b1;
                end else begin
                    box_y_next_s = box_y_r + STEP_C;
                end
            end else begin
                if (box_y_r <= STEP_C) begin
                    box_y_next_s = 11'd0;
                    dir_y_next_s = 1'b1;
                    bounce_y_s   = 1'b1;
                end else begin
                    box_y_next_s = box_y_r - STEP_C;
                end
            end
        end else begin
            box_x_next_s = box_x_r;
            box_y_next_s = box_y_r;
        end
    end

    // Colour state machine: a corner hit (both bounces) still advances once.
    always_comb begin
        colour_next_s = colour_r;
        if (bounce_x_s | bounce_y_s) begin
            case (colour_r)
                COL_RED:   colour_next_s = COL_GREEN;
                COL_GREEN: colour_next_s = COL_BLUE;
                COL_BLUE:  colour_next_s = COL_RED;
                default:   colour_next_s = COL_RED;
            endcase
        end else begin
            colour_next_s = colour_r;
        end
    end

    // Box state register: position, direction and colour.
    always_ff @(posedge board_clock or posedge reset) begin
        if (reset) begin
            box_x_r  <= INIT_X_C;
            box_y_r  <= INIT_Y_C;
            dir_x_r  <= 1'b1;
            dir_y_r  <= 1'b1;
            colour_r <= COL_RED;
        end else begin
            box_x_r  <= box_x_next_s;
            box_y_r  <= box_y_next_s;
            dir_x_r  <= dir_x_next_s;
            dir_y_r  <= dir_y_next_s;
            colour_r <= colour_next_s;
        end
    end

    // Colour state to RGB value.
    always_comb begin
        box_rgb_s = 24'hFF0000;
        case (colour_r)
            COL_RED:   box_rgb_s = 24'hFF0000;
            COL_GREEN: box_rgb_s = 24'h00FF00;
            COL_BLUE:  box_rgb_s = 24'h0000FF;
            default:   box_rgb_s = 24'hFF0000;
        endcase
    end

    assign x_ext_s  = {1'b0, s1_x_r};
    assign y_ext_s  = {1'b0, s1_y_r};
    assign in_box_s = (x_ext_s >= box_x_r) && (x_ext_s < box_x_r + BOX_C) &&
                      (y_ext_s >= box_y_r) && (y_ext_s < box_y_r + BOX_C);

    // Pixel rule on stage-1 values: blank outside active video.
    always_comb begin
        rgb_next_s = {BG_LEVEL, BG_LEVEL, BG_LEVEL};
        if (!s1_active_r) begin
            rgb_next_s = 24'h000000;
        end else if (in_box_s) begin
            rgb_next_s = box_rgb_s;
        end else begin
            rgb_next_s = {BG_LEVEL, BG_LEVEL, BG_LEVEL};
        end
    end

    // Stage 2 output register.
    always_ff @(posedge board_clock or posedge reset) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else begin
            hsync <= s1_hs_r;
            vsync <= s1_vs_r;
            red   <= rgb_next_s[23:16];
            green <= rgb_next_s[15:8];
            blue  <= rgb_next_s[7:0];
        end
    end

endmodule
